// File: rtl/mod_arith_pkg.sv
// Shared constants and types for the modular-arithmetic datapath:
// the two P-256 moduli, default datapath geometry and the converter FSM encoding.
package mod_arith_pkg;

    localparam int DEFAULT_WIDTH = 256;
    localparam int DEFAULT_DW    = 32;

    // P-256 field prime and P-256 group order
    localparam logic [255:0] MP0 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam logic [255:0] MP1 =
        256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } b2n_state_t;

endpackage

// File: rtl/mod_arith_b2n_addsub.sv
// DW-bit adder/subtractor shared by the subtract and correction passes.
// cout is the carry-out when adding and the borrow-out when subtracting.
module mod_arith_b2n_addsub #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    input  logic          sub,
    output logic [DW-1:0] s,
    output logic          cout
);

    logic [DW:0] sum;

    // The extra top bit reads as 1 exactly when a - b - cin went negative.
    always_comb begin
        if (sub)
            sum = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, cin};
        else
            sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    end

    assign s    = sum[DW-1:0];
    assign cout = sum[DW];

endmodule

// File: rtl/mod_arith_b2n.sv
// Redundant (xp - xn) to canonical residue converter: word-serial borrow-chained
// subtraction, then a conditional add-modulus pass when the difference went negative.
module mod_arith_b2n
    import mod_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DW    = DEFAULT_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flg_mod,
    input  logic [WIDTH-1:0] xp,
    input  logic [WIDTH-1:0] xn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int NCHUNK = WIDTH / DW;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0]    LAST = IW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] M0   = WIDTH'(MP0);
    localparam logic [WIDTH-1:0] M1   = WIDTH'(MP1);

    b2n_state_t       state;
    logic [IW-1:0]    idx;
    logic             cy;        // borrow in SUB, carry in FIX
    logic             mod_sel;
    logic [WIDTH-1:0] work;      // holds xp, then the difference, then the result
    logic [WIDTH-1:0] xn_r;
    logic [WIDTH-1:0] mod_val;

    logic [DW-1:0]    as_a;
    logic [DW-1:0]    as_b;
    logic             as_sub;
    logic [DW-1:0]    as_s;
    logic             as_cout;

    assign mod_val = mod_sel ? M1 : M0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        as_a   = work[idx*DW +: DW];
        as_b   = mod_val[idx*DW +: DW];
        as_sub = 1'b0;
        if (state == ST_SUB) begin
            as_b   = xn_r[idx*DW +: DW];
            as_sub = 1'b1;
        end
    end

    mod_arith_b2n_addsub #(.DW(DW)) u_addsub (
        .a    (as_a),
        .b    (as_b),
        .cin  (cy),
        .sub  (as_sub),
        .s    (as_s),
        .cout (as_cout)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the working registers are plain flops, not a memory, so they are cleared here too.
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            res     <= '0;
            work    <= '0;
            xn_r    <= '0;
            mod_sel <= 1'b0;
            idx     <= '0;
            cy      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        work    <= xp;
                        xn_r    <= xn;
                        mod_sel <= flg_mod;
                        idx     <= '0;
                        cy      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    work[idx*DW +: DW] <= as_s;
                    cy                 <= as_cout;
                    if (idx == LAST) begin
                        idx <= '0;
                        if (as_cout) begin
                            cy    <= 1'b0;
                            state <= ST_FIX;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_FIX: begin
                    // Final carry out of the top chunk is dropped: result wraps mod 2^WIDTH.
                    work[idx*DW +: DW] <= as_s;
                    cy                 <= as_cout;
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    res   <= work;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
